branch_outcome_driver: RTL and testbench
========================================

Name: branch_outcome_driver

Overview:
Initiator side of the branch predictor interface. Accepts (pc, taken) branch records through a valid/ready queue and plays each one onto the predictor's PC / BranchTaken pins using the fixed predict–resolve–settle cadence. Samples PredictedBranch at the end of the prediction window, scores it against the actual outcome, and keeps branch and mispredict counts. Sits between the trace/execute source and the predictor.

Parameters:
PC_W, 10, width of the branch PC and record PC field
DEPTH, 8, record queue depth in entries (power of 2, >=2)
PRED_LAT, 4, cycles PC is held before PredictedBranch is sampled (>=1)
SETTLE_LAT, 3, cycles PC is held after the resolve cycle (>=0)
CNT_W, 16, width of the statistics counters

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  record offered
in_ready  out  1  queue can accept a record
in_pc  in  PC_W  record branch PC
in_taken  in  1  record actual outcome
PC  out  PC_W  PC driven to the predictor
BranchTaken  out  1  actual outcome to the predictor; meaningful only while resolve_valid is high
resolve_valid  out  1  one-cycle strobe marking the resolve cycle
PredictedBranch  in  1  prediction returned by the predictor
busy  out  1  record in flight (FSM not IDLE)
result_valid  out  1  one-cycle strobe, coincident with resolve_valid
result_correct  out  1  prediction matched outcome; valid with result_valid
branch_count  out  CNT_W  records resolved, saturating
mispredict_count  out  CNT_W  mispredicted records, saturating

Behaviour:
- Reset (reset=0, async): queue emptied, FSM=IDLE, all counters 0. PC=0, BranchTaken=0, resolve_valid=0, result_valid=0, result_correct=0, busy=0. in_ready=1 once reset is released.
- Queue: push when in_valid && in_ready. in_ready = !full, registered. A pop in the same cycle does not raise in_ready while full. Pointers wrap modulo DEPTH. Order is FIFO.
- FSM states: IDLE, PREDICT, RESOLVE, SETTLE.
- IDLE: if the queue is non-empty, pop the head, load PC, latch taken, go to PREDICT with cnt=0. Otherwise PC and BranchTaken hold their last values.
- PREDICT: PC held. cnt increments each cycle. On the PRED_LAT-th cycle, register pred=PredictedBranch and go to RESOLVE.
- RESOLVE: exactly 1 cycle.
  - resolve_valid=1; BranchTaken=latched taken.
  - result_valid=1; result_correct=(pred==taken).
  - branch_count+1; mispredict_count+1 if pred!=taken. Both counters saturate at 2^CNT_W-1.
  - Go to SETTLE, or to IDLE if SETTLE_LAT=0.
- SETTLE: PC held, BranchTaken returns to 0, for SETTLE_LAT cycles.
  - Then, if the queue is non-empty, pop directly into PREDICT (no IDLE bubble).
  - Otherwise go to IDLE.
- Per-record period: PRED_LAT+1+SETTLE_LAT cycles (8 with defaults). PC changes only on a pop.
- busy=1 in PREDICT/RESOLVE/SETTLE.
- Push during a pop of the last entry: the new record is queued normally. Push while empty and IDLE: the record is popped the following cycle (1 cycle queue latency).
- Reset asserted mid-record: the record is abandoned, no counter update, outputs return to reset values asynchronously.

Decomposition:
- Package branch_pred_pkg: PC_W default constant, state enum (IDLE/PREDICT/RESOLVE/SETTLE), and a packed record struct {pc, taken}.
- Sub-module branch_rec_fifo: synchronous FIFO parameterised by DEPTH and record type. Outputs full/empty; same clock/reset.
- FSM, cadence counter, scoring and statistics live in branch_outcome_driver.

Test Plan:
- Single record pc=0, taken=1, prediction forced 0 → PC=0 from cycle 2 after push; resolve_valid and BranchTaken=1 on cycle 6; result_correct=0; branch_count=1, mispredict_count=1; busy drops after cycle 9.
- 20 back-to-back records pc=0, taken=1, prediction forced equal to taken → resolve strobes exactly 8 cycles apart; branch_count=20, mispredict_count=0.
- Push 10 records with the FSM stalled at startup → in_ready low after 8 accepted. Remaining pushes wait and are accepted as entries drain. All 10 resolve in push order; PCs checked.
- Alternating taken 1,0,1,0 with prediction stuck at 1 → result_correct 1,0,1,0; mispredict_count=2.
- Assert reset during PREDICT of the 2nd of 3 queued records → all outputs 0 immediately, counters 0, queue empty, in_ready=1 after release, no further resolve strobes.
- CNT_W=4, 17 mispredicted records → branch_count and mispredict_count both saturate at 15.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared types for the branch predictor initiator:
// FSM states and the queued branch record.
package branch_pred_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    PREDICT,
    RESOLVE,
    SETTLE
  } state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
  } branch_rec_t;

endpackage

// File: rtl/branch_rec_fifo.sv
// Synchronous record FIFO with registered full/empty flags.
// The head entry is readable combinationally.
module branch_rec_fifo
  import branch_pred_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = branch_rec_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;
  logic [AW:0]    cnt_d;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign cnt_d   = cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      cnt   <= cnt_d;
      full  <= (cnt_d == (AW+1)'(DEPTH));
      empty <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/branch_outcome_driver.sv
// Plays queued (pc, taken) records onto the predictor pins
// with a predict/resolve/settle cadence and scores results.
module branch_outcome_driver
  import branch_pred_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int DEPTH      = 8,
  parameter int PRED_LAT   = 4,
  parameter int SETTLE_LAT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             in_taken,
  output logic [PC_W-1:0]  PC,
  output logic             BranchTaken,
  output logic             resolve_valid,
  input  logic             PredictedBranch,
  output logic             busy,
  output logic             result_valid,
  output logic             result_correct,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } rec_t;

  localparam int CMAX =
    (PRED_LAT > SETTLE_LAT) ? PRED_LAT : SETTLE_LAT;
  localparam int CCW  = $clog2(CMAX + 1);

  state_t          state;
  state_t          state_d;
  logic [CCW-1:0]  cnt;
  logic [CCW-1:0]  cnt_d;
  logic            pop;
  logic            full;
  logic            empty;
  rec_t            head;
  rec_t            wrec;
  logic [PC_W-1:0] pc_q;
  logic            taken_q;
  logic            pred_q;
  logic            pred_last;
  logic            settle_last;
  logic            in_resolve;

  assign wrec.pc    = in_pc;
  assign wrec.taken = in_taken;

  branch_rec_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid),
    .wdata (wrec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign pred_last   = (int'(cnt) == PRED_LAT - 1);
  assign settle_last = (int'(cnt) == SETTLE_LAT - 1);
  assign in_resolve  = (state == RESOLVE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = PREDICT;
          cnt_d   = '0;
        end
      end
      PREDICT: begin
        if (pred_last) begin
          state_d = RESOLVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CCW'(1);
        end
      end
      RESOLVE: begin
        cnt_d   = '0;
        state_d = (SETTLE_LAT == 0) ? IDLE : SETTLE;
      end
      SETTLE: begin
        if (settle_last) begin
          cnt_d = '0;
          // Back-to-back records skip the IDLE bubble
          if (!empty) begin
            pop     = 1'b1;
            state_d = PREDICT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      pc_q             <= '0;
      taken_q          <= 1'b0;
      pred_q           <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (pop) begin
        pc_q    <= head.pc;
        taken_q <= head.taken;
      end
      if (state == PREDICT && pred_last) begin
        pred_q <= PredictedBranch;
      end
      if (in_resolve) begin
        if (branch_count != '1) begin
          branch_count <= branch_count + CNT_W'(1);
        end
        if (pred_q != taken_q
            && mispredict_count != '1) begin
          mispredict_count <= mispredict_count + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready       = ~full;
  assign PC             = pc_q;
  assign BranchTaken    = in_resolve & taken_q;
  assign resolve_valid  = in_resolve;
  assign result_valid   = in_resolve;
  assign result_correct = in_resolve & (pred_q == taken_q);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_branch_outcome_driver.sv
// Bench for branch_outcome_driver: timing-level model of the
// 8-cycle record cadence, directed scenarios, random traffic.
module tb_branch_outcome_driver;

  localparam int PW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_pc = '0;
  logic          in_taken = 1'b0;
  logic          PredictedBranch = 1'b0;

  logic          a_ready, a_bt, a_rv, a_busy, a_resv, a_rc;
  logic [PW-1:0] a_pc;
  logic [15:0]   a_bc, a_mc;
  logic          b_ready, b_bt, b_rv, b_busy, b_resv, b_rc;
  logic [PW-1:0] b_pc;
  logic [3:0]    b_bc, b_mc;

  always #5 clock = ~clock;

  branch_outcome_driver dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_pc(in_pc), .in_taken(in_taken),
    .PC(a_pc), .BranchTaken(a_bt),
    .resolve_valid(a_rv),
    .PredictedBranch(PredictedBranch),
    .busy(a_busy), .result_valid(a_resv),
    .result_correct(a_rc),
    .branch_count(a_bc), .mispredict_count(a_mc)
  );

  branch_outcome_driver #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_pc(in_pc), .in_taken(in_taken),
    .PC(b_pc), .BranchTaken(b_bt),
    .resolve_valid(b_rv),
    .PredictedBranch(PredictedBranch),
    .busy(b_busy), .result_valid(b_resv),
    .result_correct(b_rc),
    .branch_count(b_bc), .mispredict_count(b_mc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               nm, act, exp, edge_n);
    end
  endtask

  // Model: a record pushed at edge p pops at
  // max(p+1, previous pop + 8); it resolves 4 edges
  // after its pop and is counted one edge later.
  typedef struct {
    logic [PW-1:0] pc;
    logic          tk;
  } r_t;

  r_t            q[$];
  r_t            r;
  bit            has_pop;
  bit            do_push;
  int            last_pop;
  logic [PW-1:0] m_pc;
  logic          m_tk, m_pred;
  int            m_bc, m_mc;
  logic          e_rv, e_busy, e_rdy;

  int            res_edge[$];
  logic [PW-1:0] res_pc[$];
  logic          res_ok[$];
  bit            saw_full;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always begin
    @(posedge clock);
    edge_n++;
    if (!reset) begin
      q.delete();
      has_pop = 0;
      m_pc    = '0;
      m_tk    = 1'b0;
      m_pred  = 1'b0;
      m_bc    = 0;
      m_mc    = 0;
    end else begin
      do_push = in_valid && (q.size() < 8);
      if (has_pop && edge_n == last_pop + 4)
        m_pred = PredictedBranch;
      if (has_pop && edge_n == last_pop + 5) begin
        m_bc++;
        if (m_pred != m_tk) m_mc++;
      end
      if (q.size() > 0 &&
          (!has_pop || edge_n >= last_pop + 8)) begin
        r        = q.pop_front();
        m_pc     = r.pc;
        m_tk     = r.tk;
        has_pop  = 1;
        last_pop = edge_n;
      end
      if (do_push) q.push_back('{in_pc, in_taken});
    end
    #1;
    if (reset) begin
      e_rv   = has_pop && edge_n == last_pop + 4;
      e_busy = has_pop && edge_n < last_pop + 8;
      e_rdy  = q.size() < 8;
      chk("in_ready", 32'(a_ready), 32'(e_rdy));
      chk("PC", 32'(a_pc), 32'(m_pc));
      chk("resolve_valid", 32'(a_rv), 32'(e_rv));
      chk("result_valid", 32'(a_resv), 32'(e_rv));
      chk("BranchTaken", 32'(a_bt), 32'(e_rv & m_tk));
      chk("result_correct", 32'(a_rc),
          32'(e_rv & (m_pred == m_tk)));
      chk("busy", 32'(a_busy), 32'(e_busy));
      chk("branch_count", 32'(a_bc), sat(m_bc, 65535));
      chk("mispredict_count", 32'(a_mc), sat(m_mc, 65535));
      chk("w4_resolve_valid", 32'(b_rv), 32'(e_rv));
      chk("w4_branch_count", 32'(b_bc), sat(m_bc, 15));
      chk("w4_mispredict_count", 32'(b_mc), sat(m_mc, 15));
      if (a_rv) begin
        res_edge.push_back(edge_n);
        res_pc.push_back(a_pc);
        res_ok.push_back(a_rc);
      end
      if (!a_ready) saw_full = 1;
    end
  end

  task automatic clear_logs();
    res_edge.delete();
    res_pc.delete();
    res_ok.delete();
    saw_full = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    clear_logs();
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [PW-1:0] pc,
                      input logic tk);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_taken = tk;
    while (!a_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (g >= 200) chk("push_timeout", g, 0);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int g;
    g = 0;
    while (res_edge.size() < n && g < budget) begin
      @(negedge clock);
      g++;
    end
    chk("resolve_count", res_edge.size(), n);
  endtask

  int p0, nres;

  initial begin
    clear_logs();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_ready", 32'(a_ready), 1);
    chk("reset_busy", 32'(a_busy), 0);
    chk("reset_bc", 32'(a_bc), 0);

    // Single record, mispredicted
    @(negedge clock);
    PredictedBranch = 1'b0;
    p0 = edge_n + 1;
    push(10'd0, 1'b1);
    repeat (12) @(negedge clock);
    chk("t1_nres", res_edge.size(), 1);
    chk("t1_latency",
        res_edge.size() > 0 ? res_edge[0] - p0 : -1, 5);
    chk("t1_correct",
        res_ok.size() > 0 ? 32'(res_ok[0]) : 9, 0);
    chk("t1_bc", 32'(a_bc), 1);
    chk("t1_mc", 32'(a_mc), 1);
    chk("t1_busy", 32'(a_busy), 0);

    // 20 back-to-back correctly predicted records
    do_reset();
    PredictedBranch = 1'b1;
    for (int i = 0; i < 20; i++) push(10'd0, 1'b1);
    wait_res(20, 300);
    repeat (6) @(negedge clock);
    for (int i = 1; i < res_edge.size(); i++)
      chk("t2_spacing", res_edge[i] - res_edge[i-1], 8);
    chk("t2_bc", 32'(a_bc), 20);
    chk("t2_mc", 32'(a_mc), 0);
    chk("t2_w4_bc", 32'(b_bc), 15);

    // Overfill the queue; order must be preserved
    do_reset();
    PredictedBranch = 1'b0;
    for (int i = 0; i < 10; i++)
      push(PW'(100 + i), 1'(i % 2));
    wait_res(10, 200);
    chk("t3_saw_full", 32'(saw_full), 1);
    for (int i = 0; i < res_pc.size(); i++)
      chk("t3_pc_order", 32'(res_pc[i]), 100 + i);

    // Alternating outcome, prediction stuck at 1
    do_reset();
    PredictedBranch = 1'b1;
    for (int i = 0; i < 4; i++)
      push(PW'(200 + i), 1'((i + 1) % 2));
    wait_res(4, 100);
    for (int i = 0; i < res_ok.size(); i++)
      chk("t4_correct", 32'(res_ok[i]), 32'((i + 1) % 2));
    repeat (2) @(negedge clock);
    chk("t4_mc", 32'(a_mc), 2);

    // Reset during PREDICT of the 2nd of 3 records
    do_reset();
    PredictedBranch = 1'b0;
    push(PW'(300), 1'b1);
    push(PW'(301), 1'b0);
    push(PW'(302), 1'b1);
    wait_res(1, 50);
    repeat (6) @(negedge clock);
    chk("t5_busy_before", 32'(a_busy), 1);
    reset = 1'b0;
    #1;
    chk("t5_pc", 32'(a_pc), 0);
    chk("t5_busy", 32'(a_busy), 0);
    chk("t5_rv", 32'(a_rv), 0);
    chk("t5_bt", 32'(a_bt), 0);
    chk("t5_resv", 32'(a_resv), 0);
    chk("t5_rc", 32'(a_rc), 0);
    chk("t5_bc", 32'(a_bc), 0);
    chk("t5_mc", 32'(a_mc), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_ready", 32'(a_ready), 1);
    nres = res_edge.size();
    repeat (40) @(negedge clock);
    chk("t5_no_strobe", res_edge.size(), nres);
    chk("t5_idle", 32'(a_busy), 0);

    // Saturation of the 4-bit counters
    do_reset();
    PredictedBranch = 1'b0;
    for (int i = 0; i < 17; i++) push(PW'(400 + i), 1'b1);
    wait_res(17, 300);
    repeat (4) @(negedge clock);
    chk("t6_bc", 32'(a_bc), 17);
    chk("t6_mc", 32'(a_mc), 17);
    chk("t6_w4_bc", 32'(b_bc), 15);
    chk("t6_w4_mc", 32'(b_mc), 15);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid        = ($urandom % 3) != 0;
      in_pc           = PW'($urandom);
      in_taken        = 1'($urandom);
      PredictedBranch = 1'($urandom);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (100) @(negedge clock);
    chk("rand_drained", 32'(a_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
